cpu_datapath: RTL and testbench
===============================

Name: cpu_datapath

Overview:
- 8-bit processor datapath: 16×8 register file, two operand muxes, a 16-operation ALU and a write-back source mux.
- Driven cycle-by-cycle by the instruction decoder's control outputs.
- Exposes R15 for the 7-segment display logic.
- Provides a combinational halt/compare condition back to the sequencer.

Parameters:
- DATA_W, 8, datapath and register width.
- NREGS, 16, number of registers; address width is log2(NREGS)=4.

Ports:
- clk  in  1  system clock (the divided clock at top level); all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- writeEnable  in  1  commit the write-back value to register destAddress at the next rising edge.
- writeSourceSelect  in  1  write-back source: 0 = ALU result, 1 = extInputData.
- muxASelect  in  1  operand A: 0 = reg[aAddress], 1 = extInputData.
- muxBSelect  in  1  operand B: 0 = reg[bAddress], 1 = zero-extended bAddress (4-bit immediate).
- extInputData  in  8  external/switch input data.
- destAddress  in  4  write register index.
- aAddress  in  4  read port A index.
- bAddress  in  4  read port B index / immediate.
- aluOpCode  in  4  ALU operation.
- R15_out  out  8  current contents of register 15.
- haltCondition  out  1  high when operand A equals operand B (after muxes).

Behaviour:
- Reset:
  - When rst is high at a rising edge, all 16 registers become 0x00.
  - R15_out therefore reads 0x00 from that edge.
  - Reset has priority over writeEnable.
  - Reset mid-program discards the pending write.
- Register reads: combinational, asynchronous to clk.
- Register write:
  - Occurs at the rising edge when writeEnable=1 and rst=0.
  - All 16 registers, including R0, are writable.
- Same-cycle read of the register being written returns the old value (no bypass); the new value is visible after the edge.
- R15_out is a direct view of reg[15]; it updates in the same edge as a write to R15 (0 cycles extra latency).
- ALU: purely combinational, 8-bit unsigned, results truncated mod 256, no flags stored. Opcodes:
  - 0 ADD A+B
  - 1 SUB A−B
  - 2 AND
  - 3 OR
  - 4 XOR
  - 5 NOT A
  - 6 SHL A by 1 (LSB←0)
  - 7 SHR A by 1 (MSB←0)
  - 8 PASS A
  - 9 PASS B
  - 10 INC A
  - 11 DEC A
  - 12 ROL A by 1
  - 13 ROR A by 1
  - 14 SLTU (A<B ? 0x01 : 0x00)
  - 15 constant 0x00
- Wrap-around: 0xFF+0x01=0x00, 0x00−0x01=0xFF, INC 0xFF=0x00, DEC 0x00=0xFF.
- Write-back value = writeSourceSelect ? extInputData : ALU result.
- haltCondition = (opA == opB); combinational; independent of writeEnable and aluOpCode.
  - Asserted during reset if the muxed operands are equal, e.g. regs all zero → 1.
- Control inputs are sampled only at the edge; no handshake; one operation per clk cycle.
- No X propagation: every opcode yields a defined result.

Decomposition:
- Shared package cpu_pkg: DATA_W, REG_AW=4, and named constants for the 16 ALU opcodes, which the instruction decoder also uses.
- One sub-module: cpu_alu (inputs opA, opB, aluOpCode; output result).
- Register file and muxes stay inline in cpu_datapath.

Test Plan:
- Reset then load: rst=1 for 1 cycle, then writeSourceSelect=1, extInputData=0x3C, dest=15, writeEnable=1 → R15_out=0x3C after one edge; before that edge R15_out=0x00.
- ADD with wrap: R1=0xFF, R2=0x01; op=0, a=1, b=2, dest=15, WE=1 → R15_out=0x00. Repeat with op=1 and a=2, b=1 → 0x02.
- Immediate and shifts:
  - R3=0x81; op=12 (ROL), a=3, dest=15 → 0x03.
  - op=13 → 0xC0.
  - op=0 with muxBSelect=1, bAddress=5, a=3 → 0x86.
- Halt compare:
  - R4=R5=0x55, a=4, b=5 → haltCondition=1.
  - Change R5 to 0x56 → 0.
  - muxBSelect=1 with bAddress=0x5 and R4=0x05 → 1.
- Write-enable/priority:
  - WE=0 with op=0 → R15 unchanged.
  - WE=1 and rst=1 in the same cycle → all registers 0x00.
  - Reading dest in the write cycle returns the old value.
- SLTU and constant: A=0x10, B=0x20, op=14 → 0x01; swap operands → 0x00; op=15 → 0x00.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared datapath constants and ALU opcode names, also used by the instruction decoder.
package cpu_pkg;

    localparam int DATA_W = 8;
    localparam int NREGS  = 16;
    localparam int REG_AW = $clog2(NREGS);

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_AND  = 4'd2,
        ALU_OR   = 4'd3,
        ALU_XOR  = 4'd4,
        ALU_NOT  = 4'd5,
        ALU_SHL  = 4'd6,
        ALU_SHR  = 4'd7,
        ALU_PASA = 4'd8,
        ALU_PASB = 4'd9,
        ALU_INC  = 4'd10,
        ALU_DEC  = 4'd11,
        ALU_ROL  = 4'd12,
        ALU_ROR  = 4'd13,
        ALU_SLTU = 4'd14,
        ALU_ZERO = 4'd15
    } alu_op_e;

endpackage

// File: rtl/cpu_alu.sv
// Combinational 16-operation unsigned ALU; results wrap modulo 2^DATA_W, no flags.
module cpu_alu
    import cpu_pkg::*;
(
    input  logic [DATA_W-1:0] opA,
    input  logic [DATA_W-1:0] opB,
    input  logic [3:0]        aluOpCode,
    output logic [DATA_W-1:0] result
);

    // Select the operation; every opcode produces a defined value.
    always_comb begin
        result = '0;
        case (alu_op_e'(aluOpCode))
            ALU_ADD:  result = opA + opB;
            ALU_SUB:  result = opA - opB;
            ALU_AND:  result = opA & opB;
            ALU_OR:   result = opA | opB;
            ALU_XOR:  result = opA ^ opB;
            ALU_NOT:  result = ~opA;
            ALU_SHL:  result = {opA[DATA_W-2:0], 1'b0};
            ALU_SHR:  result = {1'b0, opA[DATA_W-1:1]};
            ALU_PASA: result = opA;
            ALU_PASB: result = opB;
            ALU_INC:  result = opA + 1'b1;
            ALU_DEC:  result = opA - 1'b1;
            ALU_ROL:  result = {opA[DATA_W-2:0], opA[DATA_W-1]};
            ALU_ROR:  result = {opA[0], opA[DATA_W-1:1]};
            ALU_SLTU: result = {{(DATA_W-1){1'b0}}, (opA < opB)};
            ALU_ZERO: result = '0;
            default:  result = '0;
        endcase
    end

endmodule

// File: rtl/cpu_datapath.sv
// 8-bit datapath: register file, operand muxes, ALU and write-back mux.
module cpu_datapath
    import cpu_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              writeEnable,
    input  logic              writeSourceSelect,
    input  logic              muxASelect,
    input  logic              muxBSelect,
    input  logic [DATA_W-1:0] extInputData,
    input  logic [REG_AW-1:0] destAddress,
    input  logic [REG_AW-1:0] aAddress,
    input  logic [REG_AW-1:0] bAddress,
    input  logic [3:0]        aluOpCode,
    output logic [DATA_W-1:0] R15_out,
    output logic              haltCondition
);

    logic [DATA_W-1:0] regs [NREGS];
    logic [DATA_W-1:0] op_a;
    logic [DATA_W-1:0] op_b;
    logic [DATA_W-1:0] alu_result;
    logic [DATA_W-1:0] wb_data;

    // Operand and write-back source selection; reads are asynchronous with no write bypass.
    always_comb begin
        op_a    = muxASelect ? extInputData : regs[aAddress];
        op_b    = muxBSelect ? {{(DATA_W-REG_AW){1'b0}}, bAddress} : regs[bAddress];
        wb_data = writeSourceSelect ? extInputData : alu_result;
    end

    cpu_alu u_alu (
        .opA       (op_a),
        .opB       (op_b),
        .aluOpCode (aluOpCode),
        .result    (alu_result)
    );

    // Register file update; reset clears every register and overrides a pending write.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
        end else if (writeEnable) begin
            regs[destAddress] <= wb_data;
        end
    end

    assign R15_out       = regs[NREGS-1];
    assign haltCondition = (op_a == op_b);

endmodule

// File: tb/tb_cpu_datapath.sv
// Self-checking bench for cpu_datapath: directed scenarios then random control words
// compared against an integer-arithmetic reference model.
module tb_cpu_datapath;

    logic       clk = 1'b0;
    logic       rst;
    logic       writeEnable;
    logic       writeSourceSelect;
    logic       muxASelect;
    logic       muxBSelect;
    logic [7:0] extInputData;
    logic [3:0] destAddress;
    logic [3:0] aAddress;
    logic [3:0] bAddress;
    logic [3:0] aluOpCode;
    logic [7:0] R15_out;
    logic       haltCondition;

    int total = 0;
    int bad   = 0;
    int mem [16];

    logic       halt_seen;
    logic [7:0] r15_seen;
    logic [7:0] r15_prev;

    cpu_datapath dut (
        .clk               (clk),
        .rst               (rst),
        .writeEnable       (writeEnable),
        .writeSourceSelect (writeSourceSelect),
        .muxASelect        (muxASelect),
        .muxBSelect        (muxBSelect),
        .extInputData      (extInputData),
        .destAddress       (destAddress),
        .aAddress          (aAddress),
        .bAddress          (bAddress),
        .aluOpCode         (aluOpCode),
        .R15_out           (R15_out),
        .haltCondition     (haltCondition)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [7:0] got, input logic [7:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%02h expected=%02h", tag, got, exp);
        end
    endtask

    // Reference ALU from the opcode table using plain integer arithmetic.
    function automatic int alu_ref(input int op, input int a, input int b);
        case (op)
            0:  return (a + b) % 256;
            1:  return (a - b + 256) % 256;
            2:  return a & b;
            3:  return a | b;
            4:  return a ^ b;
            5:  return 255 - a;
            6:  return (a * 2) % 256;
            7:  return a / 2;
            8:  return a;
            9:  return b;
            10: return (a + 1) % 256;
            11: return (a + 255) % 256;
            12: return (a * 2) % 256 + a / 128;
            13: return a / 2 + (a % 2) * 128;
            14: return (a < b) ? 1 : 0;
            default: return 0;
        endcase
    endfunction

    // Drive one control word, check the combinational outputs before the edge,
    // advance the model at the edge, then check R15 after it.
    task automatic apply(input bit r, input bit we, input bit ws, input bit ma, input bit mb,
                         input int ext, input int d, input int a, input int b, input int op,
                         output logic halt_o, output logic [7:0] r15_o);
        int opa, opb, wb;
        rst = r; writeEnable = we; writeSourceSelect = ws;
        muxASelect = ma; muxBSelect = mb;
        extInputData = 8'(ext); destAddress = 4'(d);
        aAddress = 4'(a); bAddress = 4'(b); aluOpCode = 4'(op);
        #1;
        opa = ma ? ext : mem[a];
        opb = mb ? b : mem[b];
        wb  = ws ? ext : alu_ref(op, opa, opb);
        check_eq("halt", {7'b0, haltCondition}, {7'b0, (opa == opb)});
        check_eq("r15_pre", R15_out, 8'(mem[15]));
        halt_o = haltCondition;
        @(posedge clk);
        if (r) begin
            foreach (mem[i]) mem[i] = 0;
        end else if (we) begin
            mem[d] = wb;
        end
        #1;
        check_eq("r15_post", R15_out, 8'(mem[15]));
        r15_o = R15_out;
    endtask

    task automatic load(input int d, input int val);
        logic h;
        logic [7:0] q;
        apply(0, 1, 1, 0, 0, val, d, 0, 0, 0, h, q);
    endtask

    initial begin
        rst = 1'b1; writeEnable = 1'b1; writeSourceSelect = 1'b1;
        muxASelect = 1'b0; muxBSelect = 1'b0; extInputData = 8'hAA;
        destAddress = 4'd15; aAddress = 4'd0; bAddress = 4'd1; aluOpCode = 4'd0;
        @(posedge clk);
        #1;
        foreach (mem[i]) mem[i] = 0;
        check_eq("reset_r15", R15_out, 8'h00);

        // Reset held with write enabled: registers read zero, halt asserted.
        apply(1, 1, 1, 0, 0, 8'hAA, 15, 0, 1, 0, halt_seen, r15_seen);
        check_eq("rst_halt", {7'b0, halt_seen}, 8'h01);
        check_eq("rst_r15", r15_seen, 8'h00);

        // Load R15 from external data.
        apply(0, 1, 1, 0, 0, 8'h3C, 15, 0, 0, 0, halt_seen, r15_seen);
        check_eq("load_r15", r15_seen, 8'h3C);

        // ADD wrap and SUB.
        load(1, 8'hFF);
        load(2, 8'h01);
        apply(0, 1, 0, 0, 0, 0, 15, 1, 2, 0, halt_seen, r15_seen);
        check_eq("add_wrap", r15_seen, 8'h00);
        apply(0, 1, 0, 0, 0, 0, 15, 2, 1, 1, halt_seen, r15_seen);
        check_eq("sub_wrap", r15_seen, 8'h02);

        // Rotates and immediate operand.
        load(3, 8'h81);
        apply(0, 1, 0, 0, 0, 0, 15, 3, 0, 12, halt_seen, r15_seen);
        check_eq("rol", r15_seen, 8'h03);
        apply(0, 1, 0, 0, 0, 0, 15, 3, 0, 13, halt_seen, r15_seen);
        check_eq("ror", r15_seen, 8'hC0);
        apply(0, 1, 0, 0, 1, 0, 15, 3, 5, 0, halt_seen, r15_seen);
        check_eq("add_imm", r15_seen, 8'h86);

        // Halt compare, with and without the immediate operand.
        load(4, 8'h55);
        load(5, 8'h55);
        apply(0, 0, 0, 0, 0, 0, 0, 4, 5, 3, halt_seen, r15_seen);
        check_eq("halt_eq", {7'b0, halt_seen}, 8'h01);
        load(5, 8'h56);
        apply(0, 0, 0, 0, 0, 0, 0, 4, 5, 3, halt_seen, r15_seen);
        check_eq("halt_ne", {7'b0, halt_seen}, 8'h00);
        load(4, 8'h05);
        apply(0, 0, 0, 0, 1, 0, 0, 4, 5, 7, halt_seen, r15_seen);
        check_eq("halt_imm", {7'b0, halt_seen}, 8'h01);

        // Write disabled leaves R15 alone.
        r15_prev = R15_out;
        apply(0, 0, 0, 0, 0, 0, 15, 4, 5, 0, halt_seen, r15_seen);
        check_eq("we_off", r15_seen, r15_prev);

        // Same-cycle read of the destination sees the old value.
        load(15, 8'h0C);
        apply(0, 1, 1, 0, 1, 8'h77, 15, 15, 12, 0, halt_seen, r15_seen);
        check_eq("no_bypass", {7'b0, halt_seen}, 8'h01);
        check_eq("bypass_new", r15_seen, 8'h77);

        // Reset beats write enable; every register then reads zero.
        apply(1, 1, 1, 0, 0, 8'hEE, 3, 0, 0, 0, halt_seen, r15_seen);
        for (int i = 0; i < 15; i++) begin
            apply(0, 1, 0, 0, 0, 0, 15, i, 0, 8, halt_seen, r15_seen);
            check_eq($sformatf("clr_r%0d", i), r15_seen, 8'h00);
        end

        // SLTU both ways and constant zero.
        load(6, 8'h10);
        load(7, 8'h20);
        apply(0, 1, 0, 0, 0, 0, 15, 6, 7, 14, halt_seen, r15_seen);
        check_eq("sltu_lt", r15_seen, 8'h01);
        apply(0, 1, 0, 0, 0, 0, 15, 7, 6, 14, halt_seen, r15_seen);
        check_eq("sltu_ge", r15_seen, 8'h00);
        load(15, 8'h99);
        apply(0, 1, 0, 0, 0, 0, 15, 6, 7, 15, halt_seen, r15_seen);
        check_eq("const0", r15_seen, 8'h00);

        // Random control words; every few cycles route a random register to R15 for visibility.
        for (int n = 0; n < 400; n++) begin
            bit r, we, ws, ma, mb;
            int d;
            r  = ($urandom_range(0, 39) == 0);
            we = $urandom_range(0, 3) != 0;
            ws = $urandom_range(0, 2) == 0;
            ma = $urandom_range(0, 3) == 0;
            mb = $urandom_range(0, 3) == 0;
            d  = (n % 4 == 3) ? 15 : $urandom_range(0, 15);
            apply(r, we, ws, ma, mb, $urandom_range(0, 255), d,
                  $urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 15),
                  halt_seen, r15_seen);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
